// File: rtl/median_pkg.sv
// Shared constants and state encoding for the median-filter window front end.
package median_pkg;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/row_window_source_if.sv
// Pixel-in / window-column-out handshake bundle for row_window_source.
interface row_window_source_if #(
  parameter int WIDTH = median_pkg::DEFAULT_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] word0;
  logic [WIDTH-1:0] word1;
  logic [WIDTH-1:0] word2;
  logic             frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, word0, word1, word2, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, word0, word1, word2, frame_done
  );
endinterface

// File: rtl/line_buffer.sv
// One-row pixel store: asynchronous read and synchronous write at the same
// address, so a read in the write cycle returns the old contents.
module line_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/row_window_source.sv
// Turns a raster pixel stream into 3-high window columns (rows r-2, r-1, r)
// using two line buffers and a single registered output stage.
module row_window_source
  import median_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LINE_W   = 16,
  parameter int NUM_ROWS = 8
) (
  input  logic               clk,
  input  logic               rst,
  row_window_source_if.slave bus
);
  localparam int COL_W = $clog2(LINE_W);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  state_t           state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             in_ready_c;
  logic             accept;
  logic             col_end;
  logic             row_end;
  logic [WIDTH-1:0] lb0_rd;
  logic [WIDTH-1:0] lb1_rd;
  logic             vld_p1;
  logic             done_p1;
  logic [WIDTH-1:0] w0_p1, w1_p1, w2_p1;

  // in_ready looks only at registered state, never at in_valid
  assign in_ready_c = !rst && ((state == FILL) || !vld_p1 || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign col_end    = (col == COL_LAST);
  assign row_end    = (row == ROW_LAST);

  line_buffer #(.WIDTH(WIDTH), .DEPTH(LINE_W)) lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  line_buffer #(.WIDTH(WIDTH), .DEPTH(LINE_W)) lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (bus.in_data),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept && col_end) begin
      unique case (state)
        FILL:    if (row == ROW_ONE) state_nxt = STREAM;
        STREAM:  if (row_end)        state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Stage p1: registered window column and its valid / frame-end flags
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= accept && (state == STREAM) && col_end && row_end;
      if (accept && (state == STREAM)) vld_p1 <= 1'b1;
      else if (bus.out_ready)          vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && (state == STREAM)) begin
      w0_p1 <= lb0_rd;
      w1_p1 <= lb1_rd;
      w2_p1 <= bus.in_data;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = vld_p1;
  assign bus.frame_done = done_p1;
  assign bus.word0      = w0_p1;
  assign bus.word1      = w1_p1;
  assign bus.word2      = w2_p1;
endmodule

// File: tb/tb_row_window_source.sv
// Bench for row_window_source: directed frame/stall/reset scenarios, then
// randomized handshake bubbles checked against a raster window model.
module tb_row_window_source;
  localparam int WIDTH          = 32;
  localparam int LINE_W         = 4;
  localparam int NUM_ROWS       = 4;
  localparam int COLS_PER_FRAME = (NUM_ROWS - 2) * LINE_W;
  localparam int RND_FRAMES     = 3;
  localparam int RND_TOTAL      = RND_FRAMES * NUM_ROWS * LINE_W;
  localparam int RND_BUDGET     = 3000;

  logic clk = 1'b0;
  logic rst;

  row_window_source_if #(.WIDTH(WIDTH)) bus ();

  row_window_source #(
    .WIDTH    (WIDTH),
    .LINE_W   (LINE_W),
    .NUM_ROWS (NUM_ROWS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [95:0] win;
  assign win = {bus.word0, bus.word1, bus.word2};

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] px(input int r, input int c);
    return 32'(r * 16 + c);
  endfunction

  function automatic logic [95:0] col3(input int base, input int r, input int c);
    return {32'(base) + px(r - 2, c), 32'(base) + px(r - 1, c), 32'(base) + px(r, c)};
  endfunction

  // random-phase model state
  logic [31:0] img [NUM_ROWS][LINE_W];
  logic [95:0] expq [$];
  logic [95:0] held_win;
  bit          held;
  bit          fd_exp;
  bit          acc_now;
  int          sent, got_cols, cyc, rr, cc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    rst = 1'b0;

    // first two rows fill the buffers without output
    for (int k = 0; k < 2 * LINE_W; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = px(k / LINE_W, k % LINE_W);
      #1;
      chk("fill_in_ready", bus.in_ready, 1);
      tick();
      chk("fill_out_valid", bus.out_valid, 0);
    end

    bus.in_data = px(2, 0);
    tick();
    chk("first_valid", bus.out_valid, 1);
    chk("first_col", win, col3(0, 2, 0));

    // downstream stall with a pending pixel
    bus.out_ready = 1'b0;
    bus.in_data   = px(2, 1);
    #1;
    chk("stall_in_ready", bus.in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_hold", win, col3(0, 2, 0));
      chk("stall_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    tick();
    chk("release_valid", bus.out_valid, 1);
    chk("release_col", win, col3(0, 2, 1));
    chk("mid_frame_done", bus.frame_done, 0);

    for (int k = 2 * LINE_W + 2; k < NUM_ROWS * LINE_W; k++) begin
      bus.in_data = px(k / LINE_W, k % LINE_W);
      tick();
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_col", win, col3(0, k / LINE_W, k % LINE_W));
    end
    chk("last_frame_done", bus.frame_done, 1);
    bus.in_valid = 1'b0;
    tick();
    chk("frame_done_pulse", bus.frame_done, 0);
    chk("drain_valid", bus.out_valid, 0);

    // next frame must refill before emitting
    for (int k = 0; k < 2 * LINE_W; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = px(k / LINE_W, k % LINE_W);
      tick();
      chk("refill_out_valid", bus.out_valid, 0);
    end
    bus.in_data = px(2, 0);
    tick();
    bus.in_data = px(2, 1);
    tick();
    chk("pre_rst_valid", bus.out_valid, 1);

    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    for (int k = 0; k < 2 * LINE_W; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h100 + px(k / LINE_W, k % LINE_W);
      tick();
      chk("post_rst_no_out", bus.out_valid, 0);
    end
    bus.in_data = 32'h100 + px(2, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_col", win, col3(32'h100, 2, 0));

    // randomized bubbles on both sides over several frames
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    sent     = 0;
    got_cols = 0;
    cyc      = 0;
    fd_exp   = 1'b0;
    held     = 1'b0;
    while ((sent < RND_TOTAL || expq.size() != 0) && cyc < RND_BUDGET) begin
      if (!bus.in_valid && sent < RND_TOTAL && $urandom_range(0, 2) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_frame_done", bus.frame_done, fd_exp);
      if (held && bus.out_valid) chk("rnd_hold", win, held_win);
      held     = bus.out_valid && !bus.out_ready;
      held_win = win;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) chk("rnd_unexpected_col", 1, 0);
        else                  chk("rnd_col", win, expq.pop_front());
        got_cols++;
      end
      fd_exp  = 1'b0;
      acc_now = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        rr = (sent / LINE_W) % NUM_ROWS;
        cc = sent % LINE_W;
        img[rr][cc] = bus.in_data;
        if (rr >= 2) expq.push_back({img[rr-2][cc], img[rr-1][cc], bus.in_data});
        fd_exp  = (rr == NUM_ROWS - 1) && (cc == LINE_W - 1);
        acc_now = 1'b1;
        sent++;
      end
      tick();
      if (acc_now) bus.in_valid = 1'b0;
      cyc++;
    end
    chk("rnd_budget", cyc < RND_BUDGET, 1);
    chk("rnd_col_count", got_cols, RND_FRAMES * COLS_PER_FRAME);
    bus.out_ready = 1'b1;
    tick();
    chk("rnd_idle_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
